// File: rtl/hdd_resp_pkg.sv
// Shared definitions for the mapper-to-HDD request responder: FSM states,
// failure codes and the default sector size.
package hdd_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } resp_state_e;

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_BOTH    = 4'd1;
    localparam logic [3:0] ERR_SEL     = 4'd2;
    localparam logic [3:0] ERR_ABSENT  = 4'd3;
    localparam logic [3:0] ERR_WP      = 4'd4;
    localparam logic [3:0] ERR_RANGE   = 4'd5;
    localparam logic [3:0] ERR_SECTOR  = 4'd6;
    localparam logic [3:0] ERR_TIMEOUT = 4'd7;

    localparam int unsigned SECTOR_SIZE = 512;

endpackage

// File: rtl/hdd_req_validator.sv
// Combinational request admission check: decides whether a latched request
// fails (and why), completes trivially (zero count) or may proceed.
module hdd_req_validator #(
    parameter int unsigned MAX_HDDS = 2
) (
    input  logic                    rd,
    input  logic                    wr,
    input  logic [1:0]              select,
    input  logic [31:0]             lba,
    input  logic [15:0]             count,
    input  logic [MAX_HDDS-1:0]     present,
    input  logic [MAX_HDDS-1:0]     write_prot,
    input  logic [32*MAX_HDDS-1:0]  capacity,
    output logic                    fail,
    output logic                    zero_count,
    output logic [3:0]              err_code
);
    import hdd_resp_pkg::*;

    logic        sel_ok;
    logic        sel_present;
    logic        sel_wp;
    logic [31:0] sel_cap;
    logic [32:0] end_lba;

    // Per-drive lookup by loop so an out-of-range select never indexes past the vectors.
    always_comb begin
        sel_present = 1'b0;
        sel_wp      = 1'b0;
        sel_cap     = '0;
        for (int i = 0; i < MAX_HDDS; i++) begin
            if (select == 2'(i)) begin
                sel_present = present[i];
                sel_wp      = write_prot[i];
                sel_cap     = capacity[32*i +: 32];
            end
        end
    end

    assign sel_ok  = (32'(select) < MAX_HDDS);
    assign end_lba = {1'b0, lba} + {17'd0, count};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        fail       = 1'b0;
        zero_count = 1'b0;
        err_code   = ERR_NONE;
        if (rd && wr) begin
            fail     = 1'b1;
            err_code = ERR_BOTH;
        end else if (!sel_ok) begin
            fail     = 1'b1;
            err_code = ERR_SEL;
        end else if (!sel_present) begin
            fail     = 1'b1;
            err_code = ERR_ABSENT;
        end else if (wr && sel_wp) begin
            fail     = 1'b1;
            err_code = ERR_WP;
        end else if (count == 16'd0) begin
            zero_count = 1'b1;
        end else if (end_lba > {1'b0, sel_cap}) begin
            fail     = 1'b1;
            err_code = ERR_RANGE;
        end
    end

endmodule

// File: rtl/hdd_request_responder.sv
// Responder for multi-sector HDD requests: validates, then issues one sector
// command per LBA with per-sector retry and timeout, pulsing done/error at the end.
module hdd_request_responder #(
    parameter int unsigned MAX_HDDS       = 2,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              hdd_select,
    input  logic [31:0]             hdd_lba,
    input  logic [15:0]             hdd_count,
    input  logic                    hdd_read,
    input  logic                    hdd_write,
    output logic                    hdd_ready,
    output logic                    hdd_done,
    output logic                    hdd_error,
    input  logic [MAX_HDDS-1:0]     hdd_present,
    input  logic [MAX_HDDS-1:0]     hdd_write_prot,
    input  logic [32*MAX_HDDS-1:0]  hdd_capacity,
    output logic                    sec_req,
    output logic                    sec_write,
    output logic                    sec_drive,
    output logic [31:0]             sec_lba,
    input  logic                    sec_ack,
    input  logic                    sec_done,
    input  logic                    sec_err,
    output logic [3:0]              err_code,
    output logic [31:0]             failed_lba,
    output logic [15:0]             sectors_done,
    output logic [2:0]              resp_state
);
    import hdd_resp_pkg::*;

    resp_state_e state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [31:0] cur_lba_q, cur_lba_d;
    logic [15:0] remaining_q, remaining_d;
    logic [7:0]  retries_q, retries_d;
    logic [23:0] timer_q, timer_d;
    logic [15:0] sectors_done_q, sectors_done_d;
    logic [3:0]  err_code_q, err_code_d;
    logic [31:0] failed_lba_q, failed_lba_d;
    logic        ready_q, ready_d, done_q, done_d, error_q, error_d;
    logic        sec_req_q, sec_req_d, sec_write_q, sec_write_d, sec_drive_q, sec_drive_d;
    logic [31:0] sec_lba_q, sec_lba_d;

    logic        v_fail, v_zero;
    logic [3:0]  v_code;
    logic        timed_out;

    hdd_req_validator #(.MAX_HDDS(MAX_HDDS)) u_validator (
        .rd         (rd_q),
        .wr         (wr_q),
        .select     (sel_q),
        .lba        (cur_lba_q),
        .count      (remaining_q),
        .present    (hdd_present),
        .write_prot (hdd_write_prot),
        .capacity   (hdd_capacity),
        .fail       (v_fail),
        .zero_count (v_zero),
        .err_code   (v_code)
    );

    assign timed_out = (timer_q == TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        cur_lba_d      = cur_lba_q;
        remaining_d    = remaining_q;
        retries_d      = retries_q;
        timer_d        = timer_q;
        sectors_done_d = sectors_done_q;
        err_code_d     = err_code_q;
        failed_lba_d   = failed_lba_q;
        sec_write_d    = sec_write_q;
        sec_drive_d    = sec_drive_q;
        sec_lba_d      = sec_lba_q;
        sec_req_d      = 1'b0;
        ready_d        = (state_q == ST_IDLE);
        // Pulses are registered off the state, landing one cycle after DONE/FAIL is entered.
        done_d         = (state_q == ST_DONE);
        error_d        = (state_q == ST_FAIL);

        case (state_q)
            ST_IDLE: begin
                if (hdd_read || hdd_write) begin
                    sel_d          = hdd_select;
                    rd_d           = hdd_read;
                    wr_d           = hdd_write;
                    cur_lba_d      = hdd_lba;
                    remaining_d    = hdd_count;
                    retries_d      = '0;
                    sectors_done_d = '0;
                    err_code_d     = ERR_NONE;
                    ready_d        = 1'b0;
                    state_d        = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (v_fail) begin
                    err_code_d   = v_code;
                    failed_lba_d = cur_lba_q;
                    state_d      = ST_FAIL;
                end else if (v_zero) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // An ack only counts once the request is actually visible to the engine.
                if (sec_req_q && sec_ack) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end else begin
                    sec_req_d   = 1'b1;
                    sec_lba_d   = cur_lba_q;
                    sec_drive_d = sel_q[0];
                    sec_write_d = wr_q;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 24'd1;
                if (sec_err || timed_out) begin
                    if (retries_q < 8'(MAX_RETRY)) begin
                        retries_d = retries_q + 8'd1;
                        state_d   = ST_ISSUE;
                    end else begin
                        err_code_d   = sec_err ? ERR_SECTOR : ERR_TIMEOUT;
                        failed_lba_d = cur_lba_q;
                        state_d      = ST_FAIL;
                    end
                end else if (sec_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                sectors_done_d = sectors_done_q + 16'd1;
                retries_d      = '0;
                if (remaining_q == 16'd1) begin
                    state_d = ST_DONE;
                end else begin
                    cur_lba_d   = cur_lba_q + 32'd1;
                    remaining_d = remaining_q - 16'd1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            cur_lba_q      <= '0;
            remaining_q    <= '0;
            retries_q      <= '0;
            timer_q        <= '0;
            sectors_done_q <= '0;
            err_code_q     <= ERR_NONE;
            failed_lba_q   <= '0;
            ready_q        <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            sec_req_q      <= 1'b0;
            sec_write_q    <= 1'b0;
            sec_drive_q    <= 1'b0;
            sec_lba_q      <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            cur_lba_q      <= cur_lba_d;
            remaining_q    <= remaining_d;
            retries_q      <= retries_d;
            timer_q        <= timer_d;
            sectors_done_q <= sectors_done_d;
            err_code_q     <= err_code_d;
            failed_lba_q   <= failed_lba_d;
            ready_q        <= ready_d;
            done_q         <= done_d;
            error_q        <= error_d;
            sec_req_q      <= sec_req_d;
            sec_write_q    <= sec_write_d;
            sec_drive_q    <= sec_drive_d;
            sec_lba_q      <= sec_lba_d;
        end
    end

    assign hdd_ready    = ready_q;
    assign hdd_done     = done_q;
    assign hdd_error    = error_q;
    assign sec_req      = sec_req_q;
    assign sec_write    = sec_write_q;
    assign sec_drive    = sec_drive_q;
    assign sec_lba      = sec_lba_q;
    assign err_code     = err_code_q;
    assign failed_lba   = failed_lba_q;
    assign sectors_done = sectors_done_q;
    assign resp_state   = state_q;

endmodule
